// File: rtl/traffic_light_monitor_pkg.sv
// Shared traffic definitions: light codes, monitor FSM encodings and the
// legal phase-successor rule used by both the controller and the monitor.
package traffic_light_monitor_pkg;

    typedef enum logic [1:0] {
        LIGHT_RED    = 2'b00,
        LIGHT_GREEN  = 2'b01,
        LIGHT_YELLOW = 2'b10,
        LIGHT_BAD    = 2'b11
    } light_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_TRACK = 2'b01,
        ST_FAULT = 2'b10
    } mon_state_t;

    function automatic logic is_legal_successor(input light_t cur, input light_t nxt);
        logic ok;
        case (cur)
            LIGHT_RED:    ok = (nxt == LIGHT_GREEN);
            LIGHT_GREEN:  ok = (nxt == LIGHT_YELLOW);
            LIGHT_YELLOW: ok = (nxt == LIGHT_RED);
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // One-hot {red, green, yellow}; the illegal code decodes to all lamps off.
    function automatic logic [2:0] light_decode(input light_t code);
        logic [2:0] onehot;
        case (code)
            LIGHT_RED:    onehot = 3'b100;
            LIGHT_GREEN:  onehot = 3'b010;
            LIGHT_YELLOW: onehot = 3'b001;
            default:      onehot = 3'b000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/traffic_light_monitor_dwell_counter.sv
// Saturating dwell counter: load-to-one on phase entry, increment per repeat
// sample, and flag when the updated count reaches the dwell limit.
module light_dwell_counter
    import traffic_light_monitor_pkg::*;
#(
    parameter logic [7:0] MAX_DWELL = 8'd200,
    parameter int          CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             hit
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(MAX_DWELL);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;
    logic             hit_s;

    // Next count and limit detection; an over-limit phase keeps re-flagging after a clear.
    always_comb begin
        count_s = count_r;
        hit_s   = 1'b0;
        if (load) begin
            count_s = CNT_ONE;
        end else if (inc) begin
            if (count_r != CNT_SAT) begin
                count_s = count_r + CNT_ONE;
            end else begin
                count_s = count_r;
            end
            hit_s = (count_s >= CNT_LIM);
        end else begin
            count_s = count_r;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= CNT_ZERO;
        end else begin
            count_r <= count_s;
        end
    end

    assign count = count_r;
    assign hit   = hit_s;

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic light sequence monitor: tracks the observed phase, pulses on legal
// transitions and raises sticky flags for sequence, code and dwell violations.
module traffic_light_monitor
    import traffic_light_monitor_pkg::*;
#(
    parameter logic [7:0] MAX_DWELL = 8'd200,
    parameter int          CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       light_in,
    input  logic             sample_en,
    input  logic             err_clr,
    output logic             red_on,
    output logic             green_on,
    output logic             yellow_on,
    output logic             phase_change,
    output logic             seq_error,
    output logic             code_error,
    output logic             dwell_error,
    output logic [CNT_W-1:0] dwell_count,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    light_t     code_s;
    mon_state_t state_r, state_s;
    light_t     phase_r, phase_s;
    logic [2:0] on_r, on_s;
    logic       pulse_r, pulse_s;
    logic       seq_r, code_r, dwell_r;
    logic       seq_set_s, code_set_s;
    logic       load_s, inc_s, cyc_inc_s;
    logic       dwell_hit_s;
    logic [CNT_W-1:0] cycle_r;

    assign code_s = light_t'(light_in);

    // Next-state and next-output decode; nothing moves without a qualified sample.
    always_comb begin
        state_s    = state_r;
        phase_s    = phase_r;
        on_s       = on_r;
        pulse_s    = 1'b0;
        seq_set_s  = 1'b0;
        code_set_s = 1'b0;
        load_s     = 1'b0;
        inc_s      = 1'b0;
        cyc_inc_s  = 1'b0;
        if (sample_en) begin
            case (state_r)
                ST_IDLE: begin
                    if (code_s == LIGHT_BAD) begin
                        code_set_s = 1'b1;
                    end else begin
                        phase_s = code_s;
                        on_s    = light_decode(code_s);
                        load_s  = 1'b1;
                        state_s = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (code_s == phase_r) begin
                        inc_s = 1'b1;
                    end else if (code_s == LIGHT_BAD) begin
                        code_set_s = 1'b1;
                        on_s       = 3'b000;
                        state_s    = ST_FAULT;
                    end else if (is_legal_successor(phase_r, code_s)) begin
                        pulse_s   = 1'b1;
                        phase_s   = code_s;
                        on_s      = light_decode(code_s);
                        load_s    = 1'b1;
                        cyc_inc_s = (phase_r == LIGHT_YELLOW);
                    end else begin
                        seq_set_s = 1'b1;
                        on_s      = 3'b000;
                        state_s   = ST_FAULT;
                    end
                end
                ST_FAULT: begin
                    // Only a RED sample is a safe point to resume tracking.
                    if (code_s == LIGHT_RED) begin
                        phase_s = LIGHT_RED;
                        on_s    = light_decode(LIGHT_RED);
                        load_s  = 1'b1;
                        state_s = ST_TRACK;
                    end else begin
                        state_s = ST_FAULT;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    on_s    = 3'b000;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered outputs; a fresh error in the clear cycle takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_r <= LIGHT_RED;
            on_r    <= 3'b000;
            pulse_r <= 1'b0;
            seq_r   <= 1'b0;
            code_r  <= 1'b0;
            dwell_r <= 1'b0;
            cycle_r <= CNT_ZERO;
        end else begin
            phase_r <= phase_s;
            on_r    <= on_s;
            pulse_r <= pulse_s;
            seq_r   <= seq_set_s   | (seq_r   & ~err_clr);
            code_r  <= code_set_s  | (code_r  & ~err_clr);
            dwell_r <= dwell_hit_s | (dwell_r & ~err_clr);
            if (cyc_inc_s) begin
                cycle_r <= cycle_r + CNT_ONE;
            end else begin
                cycle_r <= cycle_r;
            end
        end
    end

    light_dwell_counter #(
        .MAX_DWELL (MAX_DWELL),
        .CNT_W     (CNT_W)
    ) u_dwell (
        .clk   (clk),
        .reset (reset),
        .load  (load_s),
        .inc   (inc_s),
        .count (dwell_count),
        .hit   (dwell_hit_s)
    );

    assign {red_on, green_on, yellow_on} = on_r;
    assign phase_change = pulse_r;
    assign seq_error    = seq_r;
    assign code_error   = code_r;
    assign dwell_error  = dwell_r;
    assign cycle_count  = cycle_r;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed, table-driven bench for traffic_light_monitor (dwell limit set to 4).
module tb_traffic_light_monitor;

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] G = 2'b01;
    localparam logic [1:0] Y = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic       clk;
    logic       reset;
    logic [1:0] light_in;
    logic       sample_en;
    logic       err_clr;
    logic       red_on, green_on, yellow_on;
    logic       phase_change, seq_error, code_error, dwell_error;
    logic [7:0] dwell_count, cycle_count;

    typedef struct {
        logic        en;
        logic [1:0]  light;
        logic        clr;
        logic [22:0] exp;
    } vec_t;

    vec_t tbl [26];
    int   compared;
    int   mismatched;

    traffic_light_monitor #(
        .MAX_DWELL (8'd4),
        .CNT_W     (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .light_in     (light_in),
        .sample_en    (sample_en),
        .err_clr      (err_clr),
        .red_on       (red_on),
        .green_on     (green_on),
        .yellow_on    (yellow_on),
        .phase_change (phase_change),
        .seq_error    (seq_error),
        .code_error   (code_error),
        .dwell_error  (dwell_error),
        .dwell_count  (dwell_count),
        .cycle_count  (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected record: {rgy, pulse, seq, code, dwell_err, dwell_count, cycle_count}
    function automatic logic [22:0] mk(input logic [2:0] on, input logic pc, input logic seq,
                                       input logic code, input logic derr,
                                       input logic [7:0] d, input logic [7:0] c);
        return {on, pc, seq, code, derr, d, c};
    endfunction

    function automatic logic [22:0] actual();
        return {red_on, green_on, yellow_on, phase_change, seq_error, code_error,
                dwell_error, dwell_count, cycle_count};
    endfunction

    task automatic check(input string name, input logic [22:0] exp);
        logic [22:0] act;
        act = actual();
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got rgy=%b pc=%b seq=%b code=%b derr=%b dwell=%0d cycle=%0d, expected rgy=%b pc=%b seq=%b code=%b derr=%b dwell=%0d cycle=%0d",
                     name, act[22:20], act[19], act[18], act[17], act[16], act[15:8], act[7:0],
                     exp[22:20], exp[19], exp[18], exp[17], exp[16], exp[15:8], exp[7:0]);
        end
    endtask

    task automatic step(input logic en, input logic [1:0] l, input logic c);
        sample_en = en;
        light_in  = l;
        err_clr   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic setv(input int i, input logic en, input logic [1:0] l, input logic c,
                        input logic [22:0] exp);
        tbl[i] = '{en, l, c, exp};
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;

        // Normal cycle R R R G G Y R
        setv(0,  1'b1, R, 1'b0, mk(3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0));
        setv(1,  1'b1, R, 1'b0, mk(3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd0));
        setv(2,  1'b1, R, 1'b0, mk(3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd0));
        setv(3,  1'b1, G, 1'b0, mk(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0));
        setv(4,  1'b1, G, 1'b0, mk(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd0));
        setv(5,  1'b1, Y, 1'b0, mk(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0));
        setv(6,  1'b1, R, 1'b0, mk(3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1));
        // Skip R->Y, FAULT ignores G, RED resyncs
        setv(7,  1'b1, Y, 1'b0, mk(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1));
        setv(8,  1'b1, G, 1'b0, mk(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1));
        setv(9,  1'b1, R, 1'b0, mk(3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1));
        // Illegal code in TRACK, then clear without a sample
        setv(10, 1'b1, X, 1'b0, mk(3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 8'd1));
        setv(11, 1'b0, X, 1'b1, mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1));
        // Resync and dwell up to the limit of 4
        setv(12, 1'b1, R, 1'b0, mk(3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1));
        setv(13, 1'b1, R, 1'b0, mk(3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd1));
        setv(14, 1'b1, R, 1'b0, mk(3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd1));
        setv(15, 1'b1, R, 1'b0, mk(3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 8'd1));
        setv(16, 1'b0, R, 1'b1, mk(3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 8'd1));
        // New seq error in the clear cycle wins
        setv(17, 1'b1, Y, 1'b1, mk(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 8'd1));
        setv(18, 1'b1, G, 1'b0, mk(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 8'd1));
        setv(19, 1'b1, R, 1'b0, mk(3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1));
        // Unqualified samples are ignored, then a single pulse on G
        setv(20, 1'b0, G, 1'b0, mk(3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1));
        setv(21, 1'b0, X, 1'b0, mk(3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1));
        setv(22, 1'b1, G, 1'b0, mk(3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1));
        // Reverse G->R faults; resync from FAULT does not bump cycle_count
        setv(23, 1'b1, R, 1'b0, mk(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1));
        setv(24, 1'b0, R, 1'b1, mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1));
        setv(25, 1'b1, R, 1'b0, mk(3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1));

        reset     = 1'b1;
        sample_en = 1'b0;
        light_in  = R;
        err_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0));
        reset = 1'b0;

        // Illegal code in IDLE stays in IDLE; clear leaves the FSM alone
        step(1'b1, X, 1'b0);
        check("idle_code11", mk(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0));
        step(1'b0, R, 1'b1);
        check("idle_clear", mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0));

        for (int i = 0; i < 26; i++) begin
            step(tbl[i].en, tbl[i].light, tbl[i].clr);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Build a GREEN dwell of 7, then reset asynchronously mid-cycle
        step(1'b1, G, 1'b0);
        check("green_entry", mk(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1));
        for (int k = 2; k <= 7; k++) begin
            step(1'b1, G, 1'b0);
        end
        check("green_dwell7", mk(3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 8'd1));
        #3;
        reset = 1'b1;
        #1;
        check("async_reset", mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, Y, 1'b0);
        check("post_reset_yellow", mk(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0));

        // Dwell counter saturates at 255
        for (int k = 0; k < 260; k++) begin
            step(1'b1, Y, 1'b0);
        end
        check("dwell_saturate", mk(3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 8'd255, 8'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 SHALL have parameter MAX_DWELL, 8'd200, samples of one phase before the dwell-timeout error.
REQ-002 SHALL have parameter CNT_W, 8, width of dwell_count and cycle_count.
REQ-003 SHALL have port clk  input  1  clock, rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port light_in  input  2  light code under observation: 00 RED, 01 GREEN, 10 YELLOW, 11 illegal.
REQ-006 SHALL have port sample_en  input  1  qualifies light_in; light_in is ignored when low.
REQ-007 SHALL have port err_clr  input  1  clears the sticky error flags.
REQ-008 SHALL have port red_on, green_on, yellow_on  output  1 each  registered one-hot decode of the current tracked phase.
REQ-009 SHALL have port phase_change  output  1  one-cycle pulse on a legal phase transition.
REQ-010 SHALL have port seq_error  output  1  sticky flag for an illegal transition.
REQ-011 SHALL have port code_error  output  1  sticky flag for code 11 sampled.
REQ-012 SHALL have port dwell_error  output  1  sticky flag for a dwell timeout.
REQ-013 SHALL have port dwell_count  output  CNT_W  qualified samples spent in the current phase.
REQ-014 SHALL have port cycle_count  output  CNT_W  completed YELLOW->RED returns, wraps modulo 2^CNT_W.

Function
REQ-015 SHALL act only on clk edges where sample_en=1; all outputs except pulses SHALL hold otherwise, and phase_change SHALL be 0.
REQ-016 SHALL update all outputs from a sample on the clk edge that captures it, giving one-cycle latency.
REQ-017 SHALL implement the FSM states IDLE, TRACK and FAULT.
REQ-018 IDLE: on a sample with a legal code, SHALL capture that phase, set dwell_count=1, go to TRACK, and SHALL NOT pulse phase_change; on code 11, SHALL set code_error and stay in IDLE.
REQ-019 TRACK, same code: dwell_count SHALL increment, saturating at 2^CNT_W-1.
REQ-020 TRACK, same code, when dwell_count reaches MAX_DWELL: dwell_error SHALL set and the state SHALL stay TRACK.
REQ-021 TRACK, legal successor (RED->GREEN, GREEN->YELLOW, YELLOW->RED): SHALL pulse phase_change, set dwell_count=1, update the phase decode, and increment cycle_count on YELLOW->RED only.
REQ-022 TRACK, any other legal code (skip or reverse): SHALL set seq_error, clear all *_on outputs, and go to FAULT.
REQ-023 TRACK, code 11: SHALL set code_error, clear all *_on outputs, and go to FAULT.
REQ-024 FAULT: SHALL ignore all codes except RED.
REQ-025 FAULT, RED sampled: SHALL resync to TRACK with red_on=1 and dwell_count=1, with no phase_change and no cycle_count increment.
REQ-026 SHALL clear all three sticky flags on err_clr=1 regardless of sample_en.
REQ-027 SHALL let a new error in the same cycle as err_clr win, leaving that flag set.
REQ-028 SHALL NOT change FSM state or counters on err_clr.

Reset
REQ-029 On reset, SHALL asynchronously force state=IDLE, *_on=0, phase_change=0, all error flags=0, dwell_count=0 and cycle_count=0.
REQ-030 SHALL abandon any in-progress phase tracking on reset mid-operation; the first post-reset sample SHALL be treated per REQ-018.

Structure
REQ-031 SHALL place the light codes RED/GREEN/YELLOW, the FSM state encodings and a legal-successor function in the shared traffic package, common with the traffic light controller.
REQ-032 SHALL use one sub-module, light_dwell_counter: a saturating counter with load-1 and compare-to-MAX_DWELL.

Verification
REQ-033 Reset, then samples 00 x3, 01 x2, 10 x1, 00 -> phase_change pulses on the 01, 10 and final 00 samples; cycle_count=1; dwell_count=1 after the final 00.
REQ-034 Samples 00, 10 -> seq_error=1, *_on=0, FAULT; then 01 ignored; then 00 -> red_on=1, no phase_change.
REQ-035 Sample 11 in TRACK -> code_error=1 next cycle; err_clr the next cycle -> code_error=0.
REQ-036 MAX_DWELL=4, samples 01 x4 -> dwell_error=1 on the 4th sample; dwell_count=4; state still TRACK.
REQ-037 Samples 00, 01 with sample_en=0 between them for 5 cycles -> outputs hold, dwell_count unchanged, single phase_change on 01.
REQ-038 Reset asserted mid-GREEN with dwell_count=7 -> all outputs 0 immediately; first sample 10 after release -> yellow_on=1, no seq_error.
